// File: rtl/mtm_pkg.sv
// Shared definitions for the memory trace monitor: run-control state
// encoding and a constant-evaluable ceil(log2) helper for port widths.
package mtm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DATA_W simple dual-port RAM.
// Ports:
//   clk, rst          clock and synchronous active-high reset (read register only)
//   wr_en/addr/data   synchronous write port
//   rd_en/addr        read request
//   rd_data           registered read data, held when rd_en is low
// A read and write to the same address in one cycle returns the old word.
module trace_ram
    import mtm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array has no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register; sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_trace_monitor.sv
// Run-control and trace capture beside the processor core.
// A start pulse begins a run; every valid to_mem word is captured until the
// buffer fills (later words set overflow). The run ends on halt or after
// TIMEOUT cycles. The captured trace is drained through the read port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (ignored while running)
//   to_mem, to_mem_valid     observed processor output bus
//   halt                     processor finished
//   busy, done               state decodes (RUN / DONE)
//   timed_out, overflow      run status, held after the run
//   count, cycles            entries captured, cycles spent in RUN
//   rd_en, rd_addr, rd_data  registered trace read port
module mem_trace_monitor
    import mtm_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 50,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        to_mem,
    input  logic                     to_mem_valid,
    input  logic                     halt,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     overflow,
    output logic [clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]         cycles,
    input  logic                     rd_en,
    input  logic [clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t state;
    logic   buf_full;
    logic   wr_en;
    logic   last_cycle;

    // count never exceeds DEPTH, so equality is the full test.
    assign buf_full   = (count == CW'(DEPTH));
    assign wr_en      = (state == RUN) && to_mem_valid && !buf_full;
    assign last_cycle = (cycles == CNT_W'(TIMEOUT - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Run control, cycle counter and capture bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            cycles    <= '0;
            overflow  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        count     <= '0;
                        cycles    <= '0;
                        overflow  <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                RUN: begin
                    cycles <= cycles + CNT_W'(1);
                    if (to_mem_valid) begin
                        if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    // Halt beats a coincident timeout.
                    if (halt) begin
                        state     <= DONE;
                        timed_out <= 1'b0;
                    end else if (last_cycle) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_trace_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (to_mem),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Scoreboard bench for mem_trace_monitor: each run plan is evaluated by a
// plain reference model whose expected run results and read data are queued;
// a monitor pops and compares when done rises or read data is presented.
module tb_mem_trace_monitor;
    import mtm_pkg::*;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned AW      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] to_mem;
    logic              to_mem_valid;
    logic              halt;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic              overflow;
    logic [AW:0]       count;
    logic [CNT_W-1:0]  cycles;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    always #5 clk = ~clk;

    mem_trace_monitor #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .to_mem       (to_mem),
        .to_mem_valid (to_mem_valid),
        .halt         (halt),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .overflow     (overflow),
        .count        (count),
        .cycles       (cycles),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    typedef struct {
        bit to;
        bit ov;
        int cnt;
        int cyc;
    } run_exp_t;

    int checks   = 0;
    int failures = 0;

    run_exp_t          run_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                last_cnt = 0;

    // Per-run-cycle plan, index 1..TIMEOUT.
    bit                pv [TIMEOUT+1];
    bit                ph [TIMEOUT+1];
    bit                ps [TIMEOUT+1];
    logic [DATA_W-1:0] pd [TIMEOUT+1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i <= TIMEOUT; i++) begin
            pv[i] = 1'b0;
            ph[i] = 1'b0;
            ps[i] = 1'b0;
            pd[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        to_mem_valid = 1'b0;
        to_mem       = '0;
        halt         = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
    endtask

    // Evaluate the plan with the reference model, queue expectations, drive it.
    task automatic run_plan(input bit rbw);
        int                n;
        bit                to;
        int                nv;
        logic [DATA_W-1:0] words[$];
        run_exp_t          e;

        n  = TIMEOUT;
        to = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (ph[i]) begin
                n  = i;
                to = 1'b0;
                break;
            end
        end
        nv = 0;
        for (int i = 1; i <= n; i++) begin
            if (pv[i]) begin
                nv++;
                if (words.size() < DEPTH) words.push_back(pd[i]);
            end
        end
        e.to  = to;
        e.ov  = (nv > DEPTH);
        e.cnt = words.size();
        e.cyc = n;
        run_q.push_back(e);

        // Start cycle also carries a junk word that must not be captured.
        @(negedge clk);
        start        = 1'b1;
        to_mem_valid = 1'b1;
        to_mem       = DATA_W'($urandom);
        @(posedge clk);
        #1;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_done", 64'(done), 64'(0));
        chk("start_count", 64'(count), 64'(0));
        chk("start_overflow", 64'(overflow), 64'(0));
        chk("start_cycles", 64'(cycles), 64'(0));

        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start        = ps[i];
            to_mem_valid = pv[i];
            to_mem       = pd[i];
            halt         = ph[i];
            if (rbw && i == 1) begin
                rd_en   = 1'b1;
                rd_addr = '0;
                rd_q.push_back(model_mem[0]);
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge clk);
        idle_inputs();

        for (int k = 0; k < words.size(); k++) model_mem[k] = words[k];
        last_cnt = words.size();
    endtask

    // Drain captured entries while junk traffic hits the idle monitor.
    task automatic read_back(input int cnt);
        for (int a = 0; a < cnt; a++) begin
            @(negedge clk);
            rd_en        = 1'b1;
            rd_addr      = AW'(a);
            rd_q.push_back(model_mem[a]);
            to_mem_valid = 1'($urandom);
            to_mem       = DATA_W'($urandom);
            halt         = 1'($urandom);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("count_held", 64'(count), 64'(last_cnt));
        chk("done_held", 64'(done), 64'(1));
    endtask

    // Monitor: compare run results on done rising and read data after rd_en.
    initial begin : monitor
        bit                done_prev = 1'b0;
        bit                busy_prev = 1'b0;
        bit                rd_seen;
        run_exp_t          e;
        logic [DATA_W-1:0] er;
        forever begin
            @(posedge clk);
            rd_seen = (rd_en === 1'b1) && (rst === 1'b0);
            #1;
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected actual=0x%0h expected=none", rd_data);
                end else begin
                    er = rd_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(er));
                end
            end
            if (done === 1'b1 && !done_prev) begin
                if (run_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL run_unexpected actual=done expected=none");
                end else begin
                    e = run_q.pop_front();
                    chk("timed_out", 64'(timed_out), 64'(e.to));
                    chk("overflow", 64'(overflow), 64'(e.ov));
                    chk("count", 64'(count), 64'(e.cnt));
                    chk("cycles", 64'(cycles), 64'(e.cyc));
                    chk("busy_fall", 64'(busy), 64'(0));
                    chk("busy_before_done", 64'(busy_prev), 64'(1));
                end
            end
            done_prev = (done === 1'b1);
            busy_prev = (busy === 1'b1);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int halt_at;
        int dens;
        bit level;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_cycles", 64'(cycles), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_timed_out", 64'(timed_out), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Halt run: three words, halt on run cycle 5.
        clear_plan();
        pv[1] = 1'b1; pd[1] = 16'h0011;
        pv[2] = 1'b1; pd[2] = 16'h0022;
        pv[3] = 1'b1; pd[3] = 16'h0033;
        ph[5] = 1'b1;
        run_plan(1'b0);
        read_back(last_cnt);

        // Timeout run, with a read of entry 0 while it is being overwritten.
        clear_plan();
        for (int i = 1; i <= TIMEOUT; i++) begin
            pv[i] = ($urandom_range(0, 3) == 0);
            pd[i] = DATA_W'($urandom);
        end
        pv[1] = 1'b1;
        run_plan(1'b1);
        read_back(last_cnt);

        // Overflow: 20 consecutive words into a 16-entry buffer.
        clear_plan();
        for (int i = 1; i <= 20; i++) begin
            pv[i] = 1'b1;
            pd[i] = DATA_W'(16'h0100 + i - 1);
        end
        ph[21] = 1'b1;
        run_plan(1'b0);
        read_back(last_cnt);

        // Halt on the timeout cycle, with starts issued mid-run.
        clear_plan();
        ph[TIMEOUT] = 1'b1;
        ps[10]      = 1'b1;
        ps[20]      = 1'b1;
        pv[3]       = 1'b1;
        pd[3]       = 16'hBEEF;
        run_plan(1'b0);
        read_back(last_cnt);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_mem_valid = 1'b1;
            to_mem       = DATA_W'(16'h0A00 + i);
            model_mem[i] = DATA_W'(16'h0A00 + i);
            @(negedge clk);
        end
        to_mem_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_cycles", 64'(cycles), 64'(0));
        chk("midrst_overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            clear_plan();
            halt_at = $urandom_range(1, TIMEOUT + 15);
            dens    = $urandom_range(0, 4);
            level   = 1'($urandom);
            for (int i = 1; i <= TIMEOUT; i++) begin
                pv[i] = ($urandom_range(0, 3) < dens);
                pd[i] = DATA_W'($urandom);
                ps[i] = ($urandom_range(0, 15) == 0);
                ph[i] = level ? (i >= halt_at) : (i == halt_at);
            end
            run_plan(r[0]);
            read_back(last_cnt);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(run_q.size() + rd_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
